// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for ID-stage hazard detection: load-use/multi-cycle stall and forwarding selects.
// Optional statistics counters are built when HAZARD_STATS_EN is defined; otherwise they read as zero.
module hazard_scoreboard #(
    parameter int NREG       = 32,
    parameter int AW         = $clog2(NREG),
    parameter int FWD_STAGES = 3,
    parameter int MAXLAT     = 2,
    parameter int CNTW       = 32,
    parameter int SW         = $clog2(FWD_STAGES + 1),
    parameter int LW         = $clog2(MAXLAT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic            id_wr,
    input  logic [AW-1:0]   id_dst,
    input  logic [LW-1:0]   id_lat,
    input  logic            flush,
    output logic            stall,
    output logic [SW-1:0]   fwd_a,
    output logic [SW-1:0]   fwd_b,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] fwd_cnt
);

    logic          r_busy [NREG];
    logic [SW-1:0] r_age  [NREG];
    logic [LW-1:0] r_lat  [NREG];

    logic          w_rs_nr;
    logic          w_rt_nr;
    logic [SW-1:0] w_fwd_a;
    logic [SW-1:0] w_fwd_b;
    logic          w_stall;
    logic          w_wr;

    // Lookups read the pre-update state, so a self-dependency sees the older producer.
    always_comb begin
        w_rs_nr = 1'b0;
        w_rt_nr = 1'b0;
        w_fwd_a = '0;
        w_fwd_b = '0;
        if (id_rs_used && id_rs != '0 && r_busy[id_rs]) begin
            if (int'(r_age[id_rs]) < int'(r_lat[id_rs]))
                w_rs_nr = 1'b1;
            else
                w_fwd_a = r_age[id_rs];
        end
        if (id_rt_used && id_rt != '0 && r_busy[id_rt]) begin
            if (int'(r_age[id_rt]) < int'(r_lat[id_rt]))
                w_rt_nr = 1'b1;
            else
                w_fwd_b = r_age[id_rt];
        end
        w_stall = id_valid && !flush && (w_rs_nr || w_rt_nr);
        w_wr    = id_valid && !flush && !w_stall && id_wr && (id_dst != '0);
    end

    assign stall = w_stall;
    assign fwd_a = w_fwd_a;
    assign fwd_b = w_fwd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_busy[i] <= 1'b0;
                r_age[i]  <= '0;
                r_lat[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 0) begin
                    r_busy[i] <= 1'b0;
                    r_age[i]  <= '0;
                    r_lat[i]  <= '0;
                end else if (w_wr && id_dst == AW'(i)) begin
                    r_busy[i] <= 1'b1;
                    r_age[i]  <= SW'(1);
                    r_lat[i]  <= id_lat;
                end else if (r_busy[i]) begin
                    // Oldest stage writes the register file this edge; the entry retires.
                    if (r_age[i] == SW'(FWD_STAGES)) begin
                        r_busy[i] <= 1'b0;
                        r_age[i]  <= '0;
                    end else begin
                        r_age[i]  <= r_age[i] + SW'(1);
                    end
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_fwd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            if ((w_fwd_a != '0 || w_fwd_b != '0) && r_fwd_cnt != '1)
                r_fwd_cnt <= r_fwd_cnt + CNTW'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a producer-timestamp model predicts stall/forward per ID cycle.
module tb_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int FS   = 3;
    localparam int SW   = 2;
    localparam int LW   = 2;
    localparam int CNTW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            id_valid = 1'b0;
    logic [AW-1:0]   id_rs = '0;
    logic [AW-1:0]   id_rt = '0;
    logic            id_rs_used = 1'b0;
    logic            id_rt_used = 1'b0;
    logic            id_wr = 1'b0;
    logic [AW-1:0]   id_dst = '0;
    logic [LW-1:0]   id_lat = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic [SW-1:0]   fwd_a;
    logic [SW-1:0]   fwd_b;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] fwd_cnt;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr), .id_dst(id_dst),
        .id_lat(id_lat), .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    stall;
        int      fa;
        int      fb;
        longint  sc;
        longint  fc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     t_issue [NREG];
    int     lat_m   [NREG];
    longint m_sc = 0;
    longint m_fc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            t_issue[r] = -1000;
            lat_m[r]   = 0;
        end
        m_sc = 0;
        m_fc = 0;
    endtask

    // Producer issued while cyc==t is in stage (cyc - t); it can forward from stage 1..FS.
    function automatic void lookup(input int r, input logic used, output logic nr, output int f);
        int age;
        nr = 1'b0;
        f  = 0;
        age = cyc - t_issue[r];
        if (used && r != 0 && age >= 1 && age <= FS) begin
            if (age < lat_m[r]) nr = 1'b1;
            else f = age;
        end
    endfunction

    task automatic drive(input logic v, input int rs, input int rt, input logic rsu, input logic rtu,
                         input logic wr, input int dst, input int lat, input logic fl);
        exp_t e;
        logic nra, nrb;
        int   fa, fb;
        @(posedge clk);
        #1;
        id_valid = v; id_rs = AW'(rs); id_rt = AW'(rt); id_rs_used = rsu; id_rt_used = rtu;
        id_wr = wr; id_dst = AW'(dst); id_lat = LW'(lat); flush = fl;
        lookup(rs, rsu, nra, fa);
        lookup(rt, rtu, nrb, fb);
        e.stall = v && !fl && (nra || nrb);
        e.fa = fa;
        e.fb = fb;
        e.sc = m_sc;
        e.fc = m_fc;
        q.push_back(e);
`ifdef HAZARD_STATS_EN
        if (e.stall) m_sc++;
        if (fa != 0 || fb != 0) m_fc++;
`endif
        if (v && !fl && !e.stall && wr && dst != 0) begin
            t_issue[dst] = cyc;
            lat_m[dst]   = lat;
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", longint'(stall), longint'(e.stall));
            chk("fwd_a", longint'(fwd_a), longint'(e.fa));
            chk("fwd_b", longint'(fwd_b), longint'(e.fb));
            chk("stall_cnt", longint'(stall_cnt), e.sc);
            chk("fwd_cnt", longint'(fwd_cnt), e.fc);
        end
    end

    initial begin
        model_reset();
        id_valid = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1;
        #2;
        chk("reset_stall", longint'(stall), 0);
        chk("reset_fwd_a", longint'(fwd_a), 0);
        chk("reset_cnt", longint'(stall_cnt), 0);
        #21;
        id_valid = 1'b0;
        rst_n = 1'b1;

        // ALU chain
        drive(1, 1, 2, 1, 1, 1, 3, 1, 0);
        drive(1, 3, 0, 1, 0, 0, 0, 1, 0);
        drive(1, 0, 3, 0, 1, 0, 0, 1, 0);
        repeat (3) idle();
        // Load-use: the stalled reader is held in ID for a second try
        drive(1, 1, 1, 0, 0, 1, 5, 2, 0);
        drive(1, 4, 5, 1, 1, 0, 0, 1, 0);
        drive(1, 4, 5, 1, 1, 0, 0, 1, 0);
        repeat (3) idle();
        // Retirement
        drive(1, 0, 0, 0, 0, 1, 9, 1, 0);
        for (int k = 0; k < 4; k++) drive(1, 9, 9, 1, 1, 0, 0, 1, 0);
        // WAW
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
        drive(1, 7, 0, 1, 0, 0, 0, 1, 0);
        repeat (3) idle();
        // r0 writes and reads
        drive(1, 0, 0, 0, 0, 1, 0, 2, 0);
        drive(1, 0, 0, 1, 1, 0, 0, 1, 0);
        // Flushed dependent consumer: no stall, no entry for r6
        drive(1, 0, 0, 0, 0, 1, 5, 2, 0);
        drive(1, 5, 5, 1, 1, 1, 6, 2, 1);
        drive(1, 6, 6, 1, 1, 0, 0, 1, 0);
        // Self-dependency on a load in flight
        repeat (3) idle();
        drive(1, 0, 0, 0, 0, 1, 8, 2, 0);
        drive(1, 8, 0, 1, 0, 1, 8, 1, 0);
        drive(1, 8, 0, 1, 0, 1, 8, 1, 0);
        drive(1, 8, 0, 1, 0, 0, 0, 1, 0);

        // Async reset mid-cycle with three busy entries and a stalled reader in ID
        drive(1, 0, 0, 0, 0, 1, 1, 2, 0);
        drive(1, 0, 0, 0, 0, 1, 2, 2, 0);
        drive(1, 0, 0, 0, 0, 1, 4, 2, 0);
        drive(1, 4, 2, 1, 1, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_stall", longint'(stall), 0);
        chk("async_fwd_a", longint'(fwd_a), 0);
        chk("async_fwd_b", longint'(fwd_b), 0);
        chk("async_stall_cnt", longint'(stall_cnt), 0);
        chk("async_fwd_cnt", longint'(fwd_cnt), 0);
        id_valid = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(1, 4, 2, 1, 1, 0, 0, 1, 0);

        // Randomized traffic over a small register window to force frequent hazards
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 5), $urandom_range(0, 5),
                  $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 5), $urandom_range(1, 2), ($urandom_range(0, 7) == 0));
        end
        idle();
        @(negedge clk);
        #1;
        chk("queue_drained", longint'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
